fft_last_stage: RTL and testbench
=================================

Name: fft_last_stage

Overview:
- Final radix-2 butterfly of the pipelined FFT.
- Pairs adjacent complex samples (a, b) and emits a+b, then a-b, one word per i_ce, with convergent rounding to OWIDTH.
- Sits directly upstream of the bit-reversal stage. Its o_val/o_sync drive that stage's input on the same i_ce.

Parameters:
- IWIDTH, 16, bits per real/imag component at input (signed).
- OWIDTH, 17, bits per component at output; legal range IWIDTH+1 >= OWIDTH >= 2.

Ports:
- i_clk  in  1  clock.
- i_reset  in  1  reset; synchronous, active-high; clock i_clk.
- i_ce  in  1  sample enable; all state advances only when high.
- i_sync  in  1  marks the first sample (a) of an FFT frame; sampled only with i_ce.
- i_val  in  2*IWIDTH  {real, imag} signed two's complement.
- o_val  out  2*OWIDTH  {real, imag} butterfly output.
- o_sync  out  1  high for the output word that is the sum of the frame's first pair.

Behaviour:
- Reset (i_reset high at a clock edge; wins over i_ce):
  - o_val=0, o_sync=0, phase=0, pending-pair valid=0, stage registers cleared.
  - Reset mid-frame drops any buffered a and any in-flight sum/diff.
- Phase bit toggles on each i_ce.
  - i_ce with i_sync forces the current sample to be a (phase 0), even if phase was 1. The orphaned a is discarded and no output is produced for it.
  - Before the first i_sync after reset, pairing follows the phase bit; o_sync stays 0 until a synced pair emerges.
- Stage 1, on the i_ce carrying b:
  - sum = a+b and diff = a-b per component, each IWIDTH+1 bits, sign-extended, no overflow.
  - Latch sync_pair = (i_sync was high with a).
- Stage 2: the next two i_ce cycles load o_val with round(sum), then round(diff).
  - Steady-state latency: sum appears 1 i_ce after b is accepted; diff 2 i_ce after.
  - Throughput is one word per i_ce.
- Continuous stream: stage 2 outputs the diff of pair k on the same i_ce that stage 1 accepts b of pair k+1, so no bubbles occur.
- o_sync is updated only on i_ce: 1 with round(sum) of a synced pair, 0 otherwise. It is held between i_ce cycles.
- Rounding drops D = IWIDTH+1-OWIDTH LSBs.
  - D=0: pass through.
  - D>=1, convergent (round half to even): add 1 to the truncated value iff x[D-1]=1 and (x[D-2:0]!=0 or truncated LSB=1).
  - No saturation logic; the result is provably within OWIDTH range.
- i_ce gaps of any length are legal. No output or state changes while i_ce=0.

Optional Feature:
- Macro FFT_LAST_STAGE_ROUND_EN.
- Defined: convergent rounding as above.
- Undefined: plain truncation (floor, arithmetic shift right by D). Saves one adder per component; latency unchanged.

Decomposition:
- Shared package fft_pkg holds:
  - complex pack/unpack helpers (real = upper half);
  - the rounding-mode constant;
  - width-check constant D.
- One sub-module: fft_convround (parameters IWID, OWID). Combinational rounding of one component, instantiated four times (sum/diff x real/imag), with the macro selecting its body.

Test Plan:
- Basic pair, IWIDTH=16, OWIDTH=17: i_sync with a=(3,-5), then b=(1,2) -> o_val=(4,-3) with o_sync=1, next i_ce (2,-7) with o_sync=0.
- Rounding, OWIDTH=16, macro defined: a=(5,0), b=(2,0) -> sum (4,0), diff (2,0). Macro undefined -> (3,0), (1,0).
- Misaligned sync: a=(9,9), then i_sync with (5,0), then (2,0) -> (9,9) never paired; output sum (7,0) with o_sync=1 (OWIDTH=17).
- i_ce gaps: i_ce high 1 of 3 cycles, 8-sample frame -> same output sequence as continuous i_ce; o_val/o_sync constant across idle cycles.
- Reset mid-frame: assert i_reset after a accepted -> o_val=0 and o_sync=0 next cycle. Next i_sync pair processes normally with no stale a.
- Extremes, OWIDTH=16: a=b=(32767,-32768) -> sum (32767,-32768), diff (0,0), no wrap.

Source files
------------

// File: rtl/fft_pkg.sv
// ---------------------------------------------------------------------------
// fft_pkg -- shared definitions for the FFT datapath slice.
//
// Contents:
//   ROUND_EN        : 1 when the build uses convergent rounding, 0 for
//                     truncation. Selected by macro FFT_LAST_STAGE_ROUND_EN.
//   drop_bits()     : number of LSBs discarded between a butterfly result
//                     (IWIDTH+1 bits) and the output word (OWIDTH bits).
//   cplx_pack()     : build a {real, imag} word from two signed components.
//   cplx_re/im()    : extract a sign-extended component from a packed word.
//                     The real part occupies the upper half.
// The helpers work on a 64-bit container so that any component width up to
// 32 bits can share one function. All width arguments are elaboration-time
// constants at every call site.
// ---------------------------------------------------------------------------
package fft_pkg;

`ifdef FFT_LAST_STAGE_ROUND_EN
    localparam bit ROUND_EN = 1'b1;
`else
    localparam bit ROUND_EN = 1'b0;
`endif

    localparam int CPLX_MAXW = 32;

    function automatic int drop_bits(input int iwidth, input int owidth);
        return iwidth + 1 - owidth;
    endfunction

    function automatic logic [63:0] cplx_pack(input logic signed [31:0] re,
                                              input logic signed [31:0] im,
                                              input int w);
        logic [63:0] mask;
        mask = (64'd1 << w) - 64'd1;
        return ((64'(re) & mask) << w) | (64'(im) & mask);
    endfunction

    // Shift the wanted field to the top, then arithmetic-shift back down so
    // the component comes out sign-extended to 32 bits.
    function automatic logic signed [31:0] cplx_re(input logic [63:0] v,
                                                   input int w);
        logic signed [31:0] t;
        t = 32'(v >> w);
        return (t <<< (CPLX_MAXW - w)) >>> (CPLX_MAXW - w);
    endfunction

    function automatic logic signed [31:0] cplx_im(input logic [63:0] v,
                                                   input int w);
        logic signed [31:0] t;
        t = 32'(v);
        return (t <<< (CPLX_MAXW - w)) >>> (CPLX_MAXW - w);
    endfunction

endpackage

// File: rtl/fft_last_stage_if.sv
// ---------------------------------------------------------------------------
// fft_last_stage_if -- sample stream into and out of the last FFT butterfly.
//
// Signals:
//   i_ce    sample enable (one input and one output word per high cycle)
//   i_sync  first sample of an FFT frame
//   i_val   {real, imag} input sample, 2*IWIDTH bits, signed components
//   o_val   {real, imag} butterfly output, 2*OWIDTH bits
//   o_sync  output word is the sum of the frame's first pair
// Modports: master drives the i_* side (upstream), slave is the butterfly.
// ---------------------------------------------------------------------------
interface fft_last_stage_if #(
    parameter int IWIDTH = 16,
    parameter int OWIDTH = 17
);
    logic                  i_ce;
    logic                  i_sync;
    logic [2*IWIDTH-1:0]   i_val;
    logic [2*OWIDTH-1:0]   o_val;
    logic                  o_sync;

    modport master (
        output i_ce, i_sync, i_val,
        input  o_val, o_sync
    );

    modport slave (
        input  i_ce, i_sync, i_val,
        output o_val, o_sync
    );
endinterface

// File: rtl/fft_convround.sv
// ---------------------------------------------------------------------------
// fft_convround -- combinational word-width reduction of one signed value.
//
// Parameters: IWID input width, OWID output width (OWID <= IWID).
// Ports:
//   i_val  signed IWID-bit value
//   o_val  signed OWID-bit value with D = IWID-OWID LSBs removed
// Build option: FFT_LAST_STAGE_ROUND_EN defined selects convergent rounding
// (round half to even); undefined selects plain truncation (floor).
// The caller guarantees the input never reaches the one value whose rounding
// would overflow, so there is no saturation.
// ---------------------------------------------------------------------------
module fft_convround #(
    parameter int IWID = 17,
    parameter int OWID = 16
) (
    input  logic signed [IWID-1:0] i_val,
    output logic signed [OWID-1:0] o_val
);
    localparam int D = IWID - OWID;

    generate
        if (D == 0) begin : g_pass
            assign o_val = i_val;
        end else begin : g_drop
            logic signed [OWID-1:0] w_trunc;
            assign w_trunc = i_val[IWID-1:D];
`ifdef FFT_LAST_STAGE_ROUND_EN
            logic w_up;
            // Round up when above half, or exactly half and the kept LSB is
            // odd (ties go to the even neighbour).
            if (D == 1) begin : g_d1
                assign w_up = i_val[0] & w_trunc[0];
            end else begin : g_dn
                assign w_up = i_val[D-1] & ((|i_val[D-2:0]) | w_trunc[0]);
            end
            assign o_val = w_trunc + {{(OWID-1){1'b0}}, w_up};
`else
            logic w_unused_lsbs;
            assign w_unused_lsbs = ^i_val[D-1:0];
            assign o_val = w_trunc;
`endif
        end
    endgenerate
endmodule

// File: rtl/fft_last_stage.sv
// ---------------------------------------------------------------------------
// fft_last_stage -- final radix-2 butterfly of the pipelined FFT.
//
// Pairs adjacent complex samples (a, b) and emits a+b then a-b, one word per
// i_ce, reduced to OWIDTH bits per component.
//
// Parameters: IWIDTH input component width, OWIDTH output component width
//             (IWIDTH+1 >= OWIDTH >= 2).
// Ports:
//   i_clk    clock
//   i_reset  synchronous active-high reset, wins over i_ce
//   bus      fft_last_stage_if.slave: i_ce, i_sync, i_val in; o_val, o_sync out
// Build option: FFT_LAST_STAGE_ROUND_EN selects convergent rounding instead
// of truncation (see fft_convround).
// ---------------------------------------------------------------------------
module fft_last_stage
    import fft_pkg::*;
#(
    parameter int IWIDTH = 16,
    parameter int OWIDTH = 17
) (
    input  logic                 i_clk,
    input  logic                 i_reset,
    fft_last_stage_if.slave      bus
);
    localparam int SW = IWIDTH + 1;
    localparam int D  = drop_bits(IWIDTH, OWIDTH);

    logic signed [IWIDTH-1:0] w_in_re, w_in_im;
    logic signed [SW-1:0]     w_sum_re, w_sum_im, w_diff_re, w_diff_im;
    logic signed [OWIDTH-1:0] w_rs_re, w_rs_im, w_rd_re, w_rd_im;
    logic                     w_take_b;

    // Pairing state: r_phase=1 means a sample a is buffered.
    logic                     r_phase;
    logic signed [IWIDTH-1:0] r_a_re, r_a_im;
    logic                     r_a_sync;

    // Butterfly results waiting for output.
    logic signed [SW-1:0]     r_sum_re, r_sum_im, r_diff_re, r_diff_im;
    logic                     r_pair_sync;
    logic                     r_pair_vld;
    logic                     r_emit_diff;

    logic [2*OWIDTH-1:0]      r_o_val;
    logic                     r_o_sync;

    assign w_in_re = IWIDTH'(cplx_re(64'(bus.i_val), IWIDTH));
    assign w_in_im = IWIDTH'(cplx_im(64'(bus.i_val), IWIDTH));

    // A synced sample is always an a, so only an unsynced sample arriving
    // while a is buffered completes a pair.
    assign w_take_b = bus.i_ce & ~bus.i_sync & r_phase;

    assign w_sum_re  = {r_a_re[IWIDTH-1], r_a_re} + {w_in_re[IWIDTH-1], w_in_re};
    assign w_sum_im  = {r_a_im[IWIDTH-1], r_a_im} + {w_in_im[IWIDTH-1], w_in_im};
    assign w_diff_re = {r_a_re[IWIDTH-1], r_a_re} - {w_in_re[IWIDTH-1], w_in_re};
    assign w_diff_im = {r_a_im[IWIDTH-1], r_a_im} - {w_in_im[IWIDTH-1], w_in_im};

    fft_convround #(.IWID(SW), .OWID(OWIDTH)) u_rnd_sum_re (
        .i_val (r_sum_re),
        .o_val (w_rs_re)
    );
    fft_convround #(.IWID(SW), .OWID(OWIDTH)) u_rnd_sum_im (
        .i_val (r_sum_im),
        .o_val (w_rs_im)
    );
    fft_convround #(.IWID(SW), .OWID(OWIDTH)) u_rnd_diff_re (
        .i_val (r_diff_re),
        .o_val (w_rd_re)
    );
    fft_convround #(.IWID(SW), .OWID(OWIDTH)) u_rnd_diff_im (
        .i_val (r_diff_im),
        .o_val (w_rd_im)
    );

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_phase     <= 1'b0;
            r_a_re      <= '0;
            r_a_im      <= '0;
            r_a_sync    <= 1'b0;
            r_sum_re    <= '0;
            r_sum_im    <= '0;
            r_diff_re   <= '0;
            r_diff_im   <= '0;
            r_pair_sync <= 1'b0;
            r_pair_vld  <= 1'b0;
            r_emit_diff <= 1'b0;
            r_o_val     <= '0;
            r_o_sync    <= 1'b0;
        end else if (bus.i_ce) begin
            // Stage 1: buffer a, or form sum/diff when b arrives.
            if (w_take_b) begin
                r_sum_re    <= w_sum_re;
                r_sum_im    <= w_sum_im;
                r_diff_re   <= w_diff_re;
                r_diff_im   <= w_diff_im;
                r_pair_sync <= r_a_sync;
                r_phase     <= 1'b0;
            end else begin
                // An earlier a still buffered here is simply overwritten.
                r_a_re   <= w_in_re;
                r_a_im   <= w_in_im;
                r_a_sync <= bus.i_sync;
                r_phase  <= 1'b1;
            end

            // Stage 2: sum on the i_ce after b, diff on the one after that.
            // The diff slot coincides with the next pair's b, so the stage 1
            // registers are read here before being overwritten.
            if (r_emit_diff) begin
                r_o_val     <= (2*OWIDTH)'(cplx_pack(32'(w_rd_re), 32'(w_rd_im), OWIDTH));
                r_o_sync    <= 1'b0;
                r_emit_diff <= 1'b0;
            end else if (r_pair_vld) begin
                r_o_val     <= (2*OWIDTH)'(cplx_pack(32'(w_rs_re), 32'(w_rs_im), OWIDTH));
                r_o_sync    <= r_pair_sync;
                r_emit_diff <= 1'b1;
            end else begin
                r_o_sync    <= 1'b0;
            end

            if (w_take_b)
                r_pair_vld <= 1'b1;
            else if (r_emit_diff)
                r_pair_vld <= 1'b0;
        end
    end

    assign bus.o_val  = r_o_val;
    assign bus.o_sync = r_o_sync;

endmodule

// File: tb/tb_fft_last_stage.sv
// ---------------------------------------------------------------------------
// tb_fft_last_stage -- directed bench for fft_last_stage.
// Two instances share one stimulus stream: dut_a with OWIDTH=17 (lossless)
// and dut_b with OWIDTH=16 (one LSB dropped, exercises rounding).
// Expected values for dut_b depend on FFT_LAST_STAGE_ROUND_EN.
// ---------------------------------------------------------------------------
module tb_fft_last_stage;

`ifdef FFT_LAST_STAGE_ROUND_EN
    localparam bit RND = 1'b1;
`else
    localparam bit RND = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        ce = 1'b0;
    logic        sync = 1'b0;
    logic [31:0] val = '0;

    fft_last_stage_if #(.IWIDTH(16), .OWIDTH(17)) if_a ();
    fft_last_stage_if #(.IWIDTH(16), .OWIDTH(16)) if_b ();

    assign if_a.i_ce   = ce;
    assign if_a.i_sync = sync;
    assign if_a.i_val  = val;
    assign if_b.i_ce   = ce;
    assign if_b.i_sync = sync;
    assign if_b.i_val  = val;

    fft_last_stage #(.IWIDTH(16), .OWIDTH(17)) dut_a (
        .i_clk   (clk),
        .i_reset (rst),
        .bus     (if_a.slave)
    );

    fft_last_stage #(.IWIDTH(16), .OWIDTH(16)) dut_b (
        .i_clk   (clk),
        .i_reset (rst),
        .bus     (if_b.slave)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp)
            n_pass++;
        else
            $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    function automatic logic [63:0] pk(input int ow, input longint re, input longint im);
        logic [63:0] m;
        m = (64'd1 << ow) - 64'd1;
        return ((64'(re) & m) << ow) | (64'(im) & m);
    endfunction

    task automatic send(input bit s, input int re, input int im);
        logic [15:0] r16, i16;
        r16 = re[15:0];
        i16 = im[15:0];
        @(negedge clk);
        ce   = 1'b1;
        sync = s;
        val  = {r16, i16};
        @(posedge clk);
        #1;
        ce   = 1'b0;
        sync = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        ce  = 1'b0;
        @(posedge clk);
        #1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    // 8-sample frame plus two zero samples to flush the last pair.
    int sre[10] = '{10, 4, -6, 7, 100, -50, 0, 1, 0, 0};
    int sim[10] = '{1, 2, 3, -4, -100, 25, 8, -1, 0, 0};
    int ere[8]  = '{14, 6, 1, -13, 50, 150, 1, -1};
    int eim[8]  = '{3, -1, -1, 7, -75, -125, 7, 9};

    initial begin
        // Reset state
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("rst_val_a", if_a.o_val, 64'd0);
        check("rst_sync_a", if_a.o_sync, 64'd0);
        check("rst_val_b", if_b.o_val, 64'd0);
        check("rst_sync_b", if_b.o_sync, 64'd0);
        @(negedge clk);
        rst = 1'b0;

        // Basic pair
        send(1'b1, 3, -5);
        send(1'b0, 1, 2);
        check("basic_nosync_yet", if_a.o_sync, 64'd0);
        send(1'b0, 0, 0);
        check("basic_sum_a", if_a.o_val, pk(17, 4, -3));
        check("basic_sum_sync", if_a.o_sync, 64'd1);
        check("basic_sum_b", if_b.o_val, pk(16, 2, -2));
        send(1'b0, 0, 0);
        check("basic_diff_a", if_a.o_val, pk(17, 2, -7));
        check("basic_diff_sync", if_a.o_sync, 64'd0);
        check("basic_diff_b", if_b.o_val, pk(16, 1, -4));

        // Rounding: odd sums at OWIDTH=16
        do_reset();
        send(1'b1, 5, 0);
        send(1'b0, 2, 0);
        send(1'b0, 0, 0);
        check("rnd1_sum_a", if_a.o_val, pk(17, 7, 0));
        check("rnd1_sum_b", if_b.o_val, RND ? pk(16, 4, 0) : pk(16, 3, 0));
        send(1'b0, 0, 0);
        check("rnd1_diff_a", if_a.o_val, pk(17, 3, 0));
        check("rnd1_diff_b", if_b.o_val, RND ? pk(16, 2, 0) : pk(16, 1, 0));

        // Ties to even, and -1 rounding toward zero vs floor
        do_reset();
        send(1'b1, 3, -1);
        send(1'b0, 2, 0);
        send(1'b0, 0, 0);
        check("rnd2_sum_a", if_a.o_val, pk(17, 5, -1));
        check("rnd2_sum_b", if_b.o_val, RND ? pk(16, 2, 0) : pk(16, 2, -1));
        send(1'b0, 0, 0);
        check("rnd2_diff_a", if_a.o_val, pk(17, 1, -1));
        check("rnd2_diff_b", if_b.o_val, RND ? pk(16, 0, 0) : pk(16, 0, -1));

        // Misaligned sync: (9,9) orphaned
        do_reset();
        send(1'b0, 9, 9);
        send(1'b1, 5, 0);
        check("mis_no_out", if_a.o_val, 64'd0);
        send(1'b0, 2, 0);
        check("mis_no_out2", if_a.o_val, 64'd0);
        send(1'b0, 0, 0);
        check("mis_sum_a", if_a.o_val, pk(17, 7, 0));
        check("mis_sync_a", if_a.o_sync, 64'd1);
        check("mis_sync_b", if_b.o_sync, 64'd1);
        send(1'b0, 0, 0);
        check("mis_diff_a", if_a.o_val, pk(17, 3, 0));

        // Frame with continuous i_ce, then i_ce high 1 of 3 cycles
        for (int g = 0; g < 3; g += 2) begin
            do_reset();
            for (int k = 0; k < 10; k++) begin
                send(k == 0, sre[k], sim[k]);
                if (k >= 2) begin
                    check($sformatf("gap%0d_val%0d", g, k), if_a.o_val, pk(17, ere[k-2], eim[k-2]));
                    check($sformatf("gap%0d_sync%0d", g, k), if_a.o_sync, (k == 2) ? 64'd1 : 64'd0);
                end
                for (int j = 0; j < g; j++) begin
                    @(posedge clk);
                    #1;
                    if (k >= 2) begin
                        check($sformatf("gap%0d_hold_val%0d", g, k), if_a.o_val, pk(17, ere[k-2], eim[k-2]));
                        check($sformatf("gap%0d_hold_sync%0d", g, k), if_a.o_sync, (k == 2) ? 64'd1 : 64'd0);
                    end
                end
            end
        end

        // Reset mid-frame, with i_ce high during reset
        do_reset();
        send(1'b1, 3, -5);
        send(1'b0, 1, 2);
        send(1'b1, 20, 30);
        check("mid_pre_val", if_a.o_val, pk(17, 4, -3));
        check("mid_pre_sync", if_a.o_sync, 64'd1);
        @(negedge clk);
        rst  = 1'b1;
        ce   = 1'b1;
        sync = 1'b0;
        val  = {16'd0, 16'd5};
        @(posedge clk);
        #1;
        check("mid_rst_val_a", if_a.o_val, 64'd0);
        check("mid_rst_sync_a", if_a.o_sync, 64'd0);
        check("mid_rst_val_b", if_b.o_val, 64'd0);
        @(negedge clk);
        rst = 1'b0;
        ce  = 1'b0;
        send(1'b0, 1, 1);
        send(1'b1, 2, 3);
        check("mid_no_stale", if_a.o_val, 64'd0);
        send(1'b0, 1, 1);
        send(1'b0, 0, 0);
        check("mid_sum_a", if_a.o_val, pk(17, 3, 4));
        check("mid_sum_sync", if_a.o_sync, 64'd1);
        send(1'b0, 0, 0);
        check("mid_diff_a", if_a.o_val, pk(17, 1, 2));

        // Extremes: no wrap at either width
        do_reset();
        send(1'b1, 32767, -32768);
        send(1'b0, 32767, -32768);
        send(1'b0, 0, 0);
        check("ext_sum_a", if_a.o_val, pk(17, 65534, -65536));
        check("ext_sum_b", if_b.o_val, pk(16, 32767, -32768));
        send(1'b0, 0, 0);
        check("ext_diff_a", if_a.o_val, pk(17, 0, 0));
        check("ext_diff_b", if_b.o_val, pk(16, 0, 0));

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
